game_tick_sched: RTL and testbench

- Game-tick scheduler for the VGA game.
- Derives the base movement tick from `clk`, sequences game phases (idle/play/pause/over), and decides when each game object is due to move.
- Objects share one move engine; due objects are serialized onto it through a round-robin valid/ready handshake.
- Sits between the top-level input debouncers and the object-position datapath feeding the VGA renderer.

---
 rtl/game_tick_pkg.sv | 14 +
 rtl/game_tick_sched_rr_arbiter.sv | 39 +++
 rtl/game_tick_sched.sv | 263 ++++++++++++++++++++++++++
 tb/tb_game_tick_sched.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_tick_pkg.sv
// Shared definitions for the game-tick scheduler: the game phase encoding
// and the default base-tick divider (148 ms at a 50 MHz system clock).
package game_tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam int TICK_DIV_DEFAULT = 7400000;

endpackage

// File: rtl/game_tick_sched_rr_arbiter.sv
// Round-robin picker for the shared move engine. It scans the request
// vector from the pointer upward, wrapping, and returns the first hit as
// a one-hot grant plus its index. Purely combinational.
module rr_arbiter
    import game_tick_pkg::*;
#(
    parameter int N_OBJ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_OBJ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_OBJ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    // First request at or above the pointer wins; the scan wraps past the top
    always_comb begin
        int   k;
        logic found;
        k     = 0;
        found = 1'b0;
        o_gnt = '0;
        o_idx = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            k = int'(i_ptr) + i;
            if (k >= N_OBJ) begin
                k = k - N_OBJ;
            end
            if (!found && i_req[k]) begin
                found    = 1'b1;
                o_gnt[k] = 1'b1;
                o_idx    = ID_W'(k);
            end
        end
        o_any = found;
    end

endmodule

// File: rtl/game_tick_sched.sv
// Game-tick scheduler: divides clk down to the base movement tick, runs
// the IDLE/PLAY/PAUSE/OVER phase machine, counts down each object's move
// period and serializes due objects onto one move engine via valid/ready.
// Optional feature: define GAME_TICK_SCHED_STEP_EN to build the elapsed
// play-time counter (time_step); without it time_step is tied to 0.
module game_tick_sched
    import game_tick_pkg::*;
#(
    parameter int N_OBJ    = 4,
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int PER_W    = 4,
    parameter int STEP_W   = 8,
    parameter int STEP_DIV = 1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     pause,
    input  logic                     hit,
    input  logic [N_OBJ-1:0]         obj_en,
    input  logic [N_OBJ*PER_W-1:0]   obj_period,
    output logic                     mv_valid,
    output logic [$clog2(N_OBJ)-1:0] mv_id,
    input  logic                     mv_ready,
    output logic                     tick,
    output logic [1:0]               state,
    output logic                     overrun,
    output logic [STEP_W-1:0]        time_step
);

    localparam int                ID_W    = $clog2(N_OBJ);
    localparam int                DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [ID_W-1:0]   LAST_ID = ID_W'(N_OBJ - 1);

    game_state_t                   r_state;
    game_state_t                   w_nextState;
    logic                          w_clear;
    logic                          w_toOver;

    logic [DIV_W-1:0]              r_div;
    logic                          r_tick;
    logic                          w_tickProc;

    logic [N_OBJ-1:0][PER_W-1:0]   r_cnt;
    logic [N_OBJ-1:0]              w_due;
    logic [N_OBJ-1:0]              w_busy;
    logic [N_OBJ-1:0]              r_pend;

    logic                          r_valid;
    logic [ID_W-1:0]               r_id;
    logic [ID_W-1:0]               r_rrPtr;
    logic                          r_overrun;

    logic [N_OBJ-1:0]              w_gnt;
    logic [ID_W-1:0]               w_gntIdx;
    logic                          w_any;
    logic                          w_sel;

    // Phase register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Phase transitions (hit beats pause beats start); flags a fresh game or an abort
    always_comb begin
        w_nextState = r_state;
        w_clear     = 1'b0;
        w_toOver    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nextState = ST_PLAY;
                    w_clear     = 1'b1;
                end
            end
            ST_PLAY: begin
                if (hit) begin
                    w_nextState = ST_OVER;
                    w_toOver    = 1'b1;
                end else if (pause) begin
                    w_nextState = ST_PAUSE;
                end else if (start) begin
                    w_clear     = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (hit) begin
                    w_nextState = ST_OVER;
                    w_toOver    = 1'b1;
                end else if (pause) begin
                    w_nextState = ST_PLAY;
                end else if (start) begin
                    w_nextState = ST_PLAY;
                    w_clear     = 1'b1;
                end
            end
            ST_OVER: begin
                if (start) begin
                    w_nextState = ST_PLAY;
                    w_clear     = 1'b1;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Base divider runs only while playing; the wrap raises tick one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else if (w_clear) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else if (r_state == ST_PLAY && !w_toOver) begin
            if (r_div == DIV_MAX) begin
                r_div  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_div  <= r_div + DIV_W'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    // A tick is acted on unless the game is being restarted or aborted this cycle
    assign w_tickProc = r_tick && (r_state == ST_PLAY || r_state == ST_PAUSE)
                        && !w_toOver && !w_clear;

    // Per-object countdowns: reload on expiry, hold at zero while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_clear) begin
            r_cnt <= '0;
        end else begin
            for (int k = 0; k < N_OBJ; k++) begin
                if (!obj_en[k]) begin
                    r_cnt[k] <= '0;
                end else if (w_tickProc) begin
                    if (r_cnt[k] == '0) begin
                        r_cnt[k] <= obj_period[k*PER_W +: PER_W];
                    end else begin
                        r_cnt[k] <= r_cnt[k] - PER_W'(1);
                    end
                end
            end
        end
    end

    // Which objects fall due on this tick, and which one is stuck on the engine
    always_comb begin
        w_due  = '0;
        w_busy = '0;
        for (int k = 0; k < N_OBJ; k++) begin
            w_due[k] = w_tickProc && obj_en[k] && (r_cnt[k] == '0);
        end
        if (r_valid && !mv_ready) begin
            w_busy[r_id] = 1'b1;
        end
    end

    rr_arbiter #(
        .N_OBJ (N_OBJ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req (r_pend),
        .i_ptr (r_rrPtr),
        .o_gnt (w_gnt),
        .o_idx (w_gntIdx),
        .o_any (w_any)
    );

    // A new pick is allowed only in PLAY and only when the engine slot is free or freeing
    assign w_sel = w_any && (r_state == ST_PLAY) && (!r_valid || mv_ready);

    // Pending flags and the presented request; restart and abort both empty the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_rrPtr <= '0;
        end else if (w_clear || w_toOver) begin
            r_pend  <= '0;
            r_valid <= 1'b0;
            if (w_clear) begin
                r_id    <= '0;
                r_rrPtr <= '0;
            end
        end else begin
            r_pend <= (r_pend & ~(w_sel ? w_gnt : '0)) | w_due;
            if (w_sel) begin
                r_valid <= 1'b1;
                r_id    <= w_gntIdx;
                r_rrPtr <= (w_gntIdx == LAST_ID) ? '0 : w_gntIdx + ID_W'(1);
            end else if (mv_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Sticky overrun: an object came due again before its last move was served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_clear) begin
            r_overrun <= 1'b0;
        end else if (|(w_due & (r_pend | w_busy))) begin
            r_overrun <= 1'b1;
        end
    end

    assign mv_valid = r_valid;
    assign mv_id    = r_id;
    assign tick     = r_tick;
    assign state    = r_state;
    assign overrun  = r_overrun;

`ifdef GAME_TICK_SCHED_STEP_EN
    localparam int               SUB_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(STEP_DIV - 1);

    logic [SUB_W-1:0]  r_stepSub;
    logic [STEP_W-1:0] r_timeStep;

    // Elapsed play time: one step every STEP_DIV ticks, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stepSub  <= '0;
            r_timeStep <= '0;
        end else if (w_clear) begin
            r_stepSub  <= '0;
            r_timeStep <= '0;
        end else if (w_tickProc) begin
            if (r_stepSub == SUB_MAX) begin
                r_stepSub <= '0;
                if (r_timeStep != '1) begin
                    r_timeStep <= r_timeStep + STEP_W'(1);
                end
            end else begin
                r_stepSub <= r_stepSub + SUB_W'(1);
            end
        end
    end

    assign time_step = r_timeStep;
`else
    logic w_unusedStepDiv;
    assign w_unusedStepDiv = (STEP_DIV > 1);
    assign time_step       = '0;
`endif

endmodule

// File: tb/tb_game_tick_sched.sv
// Directed bench for game_tick_sched with a short divider (10) and step
// divider (3). Each scenario task drives its own stimulus and checks the
// outputs against hand-derived values one cycle at a time.
module tb_game_tick_sched;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        pause;
    logic        hit;
    logic [3:0]  obj_en;
    logic [15:0] obj_period;
    logic        mv_valid;
    logic [1:0]  mv_id;
    logic        mv_ready;
    logic        tick;
    logic [1:0]  state;
    logic        overrun;
    logic [7:0]  time_step;

    int vecCount;
    int missCount;

    game_tick_sched #(
        .N_OBJ    (4),
        .TICK_DIV (10),
        .PER_W    (4),
        .STEP_W   (8),
        .STEP_DIV (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .hit        (hit),
        .obj_en     (obj_en),
        .obj_period (obj_period),
        .mv_valid   (mv_valid),
        .mv_id      (mv_id),
        .mv_ready   (mv_ready),
        .tick       (tick),
        .state      (state),
        .overrun    (overrun),
        .time_step  (time_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a stuck run still reports and ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulsePause();
        pause = 1'b1;
        step(1);
        pause = 1'b0;
    endtask

    task automatic waitTick(output int n);
        n = 0;
        while (tick !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        hit        = 1'b0;
        obj_en     = 4'b0000;
        obj_period = 16'h0000;
        mv_ready   = 1'b0;
        step(2);
        vecCount++;
        if (state !== 2'd0) begin
            missCount++;
            $display("[TB] FAIL reset_state: got %0d expected 0", state);
        end
        vecCount++;
        if ({mv_valid, mv_id, tick, overrun} !== 5'b0) begin
            missCount++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000",
                     {mv_valid, mv_id, tick, overrun});
        end
        vecCount++;
        if (time_step !== 8'd0) begin
            missCount++;
            $display("[TB] FAIL reset_time_step: got %0d expected 0", time_step);
        end
        rst_n = 1'b1;
        step(3);
        vecCount++;
        if ({state, mv_valid, tick, overrun} !== 5'b0) begin
            missCount++;
            $display("[TB] FAIL idle_outputs: got %b expected 00000",
                     {state, mv_valid, tick, overrun});
        end
        pulseStart();
        vecCount++;
        if (state !== 2'd1) begin
            missCount++;
            $display("[TB] FAIL start_to_play: got %0d expected 1", state);
        end
        waitTick(n);
        vecCount++;
        if (n !== 10) begin
            missCount++;
            $display("[TB] FAIL first_tick_latency: got %0d expected 10", n);
        end
        step(1);
        vecCount++;
        if (tick !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL tick_one_cycle: got %b expected 0", tick);
        end
    endtask

    task automatic test_periods();
        int cnt[4];
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        obj_en     = 4'b0111;
        obj_period = {4'd0, 4'd3, 4'd1, 4'd0};
        mv_ready   = 1'b1;
        pulseStart();
        for (int c = 0; c < 85; c++) begin
            step(1);
            if (mv_valid === 1'b1) cnt[mv_id]++;
        end
        vecCount++;
        if (cnt[0] !== 8) begin
            missCount++;
            $display("[TB] FAIL period_obj0: got %0d grants expected 8", cnt[0]);
        end
        vecCount++;
        if (cnt[1] !== 4) begin
            missCount++;
            $display("[TB] FAIL period_obj1: got %0d grants expected 4", cnt[1]);
        end
        vecCount++;
        if (cnt[2] !== 2) begin
            missCount++;
            $display("[TB] FAIL period_obj2: got %0d grants expected 2", cnt[2]);
        end
        vecCount++;
        if (cnt[3] !== 0) begin
            missCount++;
            $display("[TB] FAIL period_obj3: got %0d grants expected 0", cnt[3]);
        end
        vecCount++;
        if (overrun !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL period_no_overrun: got %b expected 0", overrun);
        end
    endtask

    task automatic test_round_robin();
        int n;
        obj_en     = 4'b0111;
        obj_period = 16'h0000;
        mv_ready   = 1'b0;
        pulseStart();
        waitTick(n);
        step(1);
        vecCount++;
        if (mv_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL rr_pending_cycle: got valid %b expected 0", mv_valid);
        end
        step(1);
        vecCount++;
        if ({mv_valid, mv_id} !== 3'b100) begin
            missCount++;
            $display("[TB] FAIL rr_first_grant: got %b expected 100", {mv_valid, mv_id});
        end
        for (int i = 0; i < 5; i++) begin
            step(1);
            vecCount++;
            if ({mv_valid, mv_id} !== 3'b100) begin
                missCount++;
                $display("[TB] FAIL rr_hold_%0d: got %b expected 100", i, {mv_valid, mv_id});
            end
        end
        mv_ready = 1'b1;
        step(1);
        vecCount++;
        if ({mv_valid, mv_id} !== 3'b101) begin
            missCount++;
            $display("[TB] FAIL rr_second_grant: got %b expected 101", {mv_valid, mv_id});
        end
        step(1);
        vecCount++;
        if ({mv_valid, mv_id} !== 3'b110) begin
            missCount++;
            $display("[TB] FAIL rr_third_grant: got %b expected 110", {mv_valid, mv_id});
        end
        step(1);
        vecCount++;
        if (mv_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL rr_drained: got valid %b expected 0", mv_valid);
        end
        mv_ready = 1'b0;
    endtask

    task automatic test_overrun();
        int n;
        obj_en     = 4'b0001;
        obj_period = 16'h0000;
        mv_ready   = 1'b0;
        pulseStart();
        waitTick(n);
        step(2);
        vecCount++;
        if ({mv_valid, overrun} !== 2'b10) begin
            missCount++;
            $display("[TB] FAIL overrun_before: got %b expected 10", {mv_valid, overrun});
        end
        waitTick(n);
        step(1);
        vecCount++;
        if (overrun !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL overrun_set: got %b expected 1", overrun);
        end
        mv_ready = 1'b1;
        step(25);
        vecCount++;
        if (overrun !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL overrun_sticky: got %b expected 1", overrun);
        end
        pulseStart();
        vecCount++;
        if ({state, mv_valid, overrun} !== 4'b0100) begin
            missCount++;
            $display("[TB] FAIL overrun_cleared: got %b expected 0100",
                     {state, mv_valid, overrun});
        end
        mv_ready = 1'b0;
    endtask

    task automatic test_pause_hit();
        int n;
        int seen;
        obj_en     = 4'b0001;
        obj_period = 16'h0000;
        mv_ready   = 1'b0;
        pulseStart();
        step(3);
        pulsePause();
        vecCount++;
        if (state !== 2'd2) begin
            missCount++;
            $display("[TB] FAIL pause_enter: got %0d expected 2", state);
        end
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (tick !== 1'b0) seen++;
        end
        vecCount++;
        if (seen !== 0) begin
            missCount++;
            $display("[TB] FAIL pause_tick_silent: got %0d ticks expected 0", seen);
        end
        pulsePause();
        vecCount++;
        if (state !== 2'd1) begin
            missCount++;
            $display("[TB] FAIL pause_resume: got %0d expected 1", state);
        end
        waitTick(n);
        vecCount++;
        if (n !== 6) begin
            missCount++;
            $display("[TB] FAIL pause_held_count: got %0d cycles expected 6", n);
        end
        step(2);
        vecCount++;
        if (mv_valid !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL hit_precondition: got valid %b expected 1", mv_valid);
        end
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        vecCount++;
        if ({state, mv_valid} !== 3'b110) begin
            missCount++;
            $display("[TB] FAIL hit_abort: got %b expected 110", {state, mv_valid});
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (tick !== 1'b0 || mv_valid !== 1'b0) seen++;
        end
        vecCount++;
        if (seen !== 0) begin
            missCount++;
            $display("[TB] FAIL over_quiet: got %0d active cycles expected 0", seen);
        end
    endtask

    task automatic test_pause_tick();
        int n;
        obj_en     = 4'b0001;
        obj_period = 16'h0000;
        mv_ready   = 1'b1;
        pulseStart();
        waitTick(n);
        pulsePause();
        step(3);
        vecCount++;
        if ({state, mv_valid} !== 3'b100) begin
            missCount++;
            $display("[TB] FAIL pause_tick_frozen: got %b expected 100", {state, mv_valid});
        end
        pulsePause();
        step(1);
        vecCount++;
        if ({mv_valid, mv_id} !== 3'b100) begin
            missCount++;
            $display("[TB] FAIL pause_tick_processed: got %b expected 100", {mv_valid, mv_id});
        end
        mv_ready = 1'b0;
    endtask

    task automatic test_step();
        int n;
        obj_en   = 4'b0000;
        mv_ready = 1'b0;
        pulseStart();
        for (int t = 0; t < 6; t++) begin
            waitTick(n);
            vecCount++;
            if (n >= 40) begin
                missCount++;
                $display("[TB] FAIL step_tick_%0d: got timeout expected tick", t);
            end
            step(1);
        end
        vecCount++;
`ifdef GAME_TICK_SCHED_STEP_EN
        if (time_step !== 8'd2) begin
            missCount++;
            $display("[TB] FAIL step_count: got %0d expected 2", time_step);
        end
`else
        if (time_step !== 8'd0) begin
            missCount++;
            $display("[TB] FAIL step_tied_off: got %0d expected 0", time_step);
        end
`endif
    endtask

    task automatic test_async_reset();
        int n;
        obj_en     = 4'b0001;
        obj_period = 16'h0000;
        mv_ready   = 1'b0;
        pulseStart();
        waitTick(n);
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        vecCount++;
        if ({state, mv_valid, overrun} !== 4'b0000) begin
            missCount++;
            $display("[TB] FAIL async_reset: got %b expected 0000",
                     {state, mv_valid, overrun});
        end
        #2;
        rst_n = 1'b1;
        step(2);
        vecCount++;
        if ({state, tick} !== 3'b000) begin
            missCount++;
            $display("[TB] FAIL after_reset_idle: got %b expected 000", {state, tick});
        end
    endtask

    // Scenario sequence
    initial begin
        vecCount  = 0;
        missCount = 0;
        test_reset();
        test_periods();
        test_round_robin();
        test_overrun();
        test_pause_hit();
        test_pause_tick();
        test_step();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
